// File: rtl/arvi_pkg.sv
// rtl/arvi_pkg.sv - shared types and constants for the fetch stage
package arvi_pkg;

   localparam int XLEN = 32;
   localparam logic [31:0] INST_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
      logic            exc;
   } fetch_entry_t;

   localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - req/ack instruction bus between fetch stage and memory
interface if_stage_if import arvi_pkg::*; ();

   logic            req;
   logic [XLEN-1:0] addr;
   logic            ack;
   logic [31:0]     data;

   modport master (output req, output addr, input ack, input data);
   modport slave  (input req, input addr, output ack, output data);

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO; flush wins over push, push at full allowed with pop
module fetch_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && !flush && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rstn || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage (IF_MISALIGN_EXC_EN: misaligned redirect raises fetch exception)
module if_stage import arvi_pkg::*; #(
   parameter logic [XLEN-1:0] PC_RESET   = '0,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   if_stage_if.master        ibus,
   input  logic              i_stall,
   input  logic              i_redirect,
   input  logic [XLEN-1:0]   i_redirect_pc,
   output logic [31:0]       o_inst,
   output logic [XLEN-1:0]   o_pc,
   output logic              o_valid,
   output logic              o_exc
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_t    state, state_nx;
   logic [XLEN-1:0] fetch_pc, fetch_pc_nx;
   logic [XLEN-1:0] target;
   logic            misalign;
   logic            blocked, blocked_nx;
   logic            exc_pend;
   logic            ack_push, exc_push, push, pop, issue, can_issue;
   logic            fifo_full, fifo_empty;
   logic [CW-1:0]   count, count_nx;
   fetch_entry_t    push_entry, head;
   logic [ENTRY_W-1:0] head_bits;

`ifdef IF_MISALIGN_EXC_EN
   assign target   = i_redirect_pc;
   assign misalign = |i_redirect_pc[1:0];
`else
   assign target   = i_redirect_pc & ~XLEN'(3);
   assign misalign = 1'b0;
`endif

   fetch_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (i_clk),
      .rstn      (i_rstn),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (i_redirect),
      .head      (head_bits),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (count)
   );

   assign head    = fetch_entry_t'(head_bits);
   assign o_valid = !fifo_empty;
   assign o_inst  = fifo_empty ? INST_NOP : head.inst;
   assign o_pc    = fifo_empty ? '0 : head.pc;
   assign o_exc   = !fifo_empty && head.exc;

   always_comb begin
      ack_push = (state == REQ) && ibus.ack && !i_redirect;
      // Exception entry is pushed the cycle after the redirect so the flush cannot swallow it.
      exc_push = exc_pend && !i_redirect;
      pop      = !fifo_empty && !i_stall;
      push     = (ack_push || exc_push) && (!fifo_full || pop);
      push_entry.pc   = fetch_pc;
      push_entry.inst = exc_push ? INST_NOP : ibus.data;
      push_entry.exc  = exc_push;

      count_nx    = i_redirect ? '0 : count + CW'(push) - CW'(pop);
      blocked_nx  = i_redirect ? misalign : blocked;
      fetch_pc_nx = i_redirect ? target : (ack_push ? fetch_pc + XLEN'(4) : fetch_pc);
      can_issue   = !blocked_nx && (count_nx < CW'(FIFO_DEPTH));

      issue    = 1'b0;
      state_nx = state;
      case (state)
         IDLE:    issue = can_issue;
         REQ: begin
            if (ibus.ack) begin
               issue    = can_issue;
               state_nx = IDLE;
            end else if (i_redirect) begin
               state_nx = DISCARD;
            end
         end
         DISCARD: begin
            if (ibus.ack) begin
               issue    = can_issue;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
      if (issue) state_nx = REQ;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state     <= IDLE;
         fetch_pc  <= PC_RESET;
         blocked   <= 1'b0;
         exc_pend  <= 1'b0;
         ibus.req  <= 1'b0;
         ibus.addr <= PC_RESET;
      end else begin
         state    <= state_nx;
         fetch_pc <= fetch_pc_nx;
         blocked  <= blocked_nx;
         exc_pend <= i_redirect && misalign;
         ibus.req <= (state_nx != IDLE);
         if (issue) ibus.addr <= fetch_pc_nx;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;
   import arvi_pkg::*;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic            stall = 1'b0;
   logic            redirect = 1'b0;
   logic [XLEN-1:0] redirect_pc = '0;
   logic [31:0]     inst;
   logic [XLEN-1:0] pc;
   logic            valid;
   logic            exc;

   if_stage_if ibus ();

   if_stage #(.PC_RESET('0), .FIFO_DEPTH(2)) dut (
      .i_clk         (clk),
      .i_rstn        (rstn),
      .ibus          (ibus),
      .i_stall       (stall),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc),
      .o_inst        (inst),
      .o_pc          (pc),
      .o_valid       (valid),
      .o_exc         (exc)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;
   int lat = 0;
   int wait_cnt = 0;
   int cyc = 0;
   int first_ack = -1;
   int first_valid = -1;
   bit fired = 1'b0;
   logic [31:0] acc_q[$];
   logic [31:0] pc_q[$];
   logic [31:0] inst_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One cycle: drive inputs and the memory model at negedge, then log what the next posedge will do.
   task automatic step(input bit st, input bit rd, input logic [31:0] rpc);
      @(negedge clk);
      cyc++;
      stall = st;
      redirect = rd;
      redirect_pc = rpc;
      if (fired) wait_cnt = 0;
      if (ibus.req) begin
         if (wait_cnt >= lat) begin
            ibus.ack  = 1'b1;
            ibus.data = ibus.addr + 32'h1000_0000;
         end else begin
            ibus.ack = 1'b0;
            wait_cnt++;
         end
      end else begin
         ibus.ack = 1'b0;
         wait_cnt = 0;
      end
      fired = rstn && ibus.req && ibus.ack;
      if (fired) begin
         acc_q.push_back(ibus.addr);
         if (first_ack < 0) first_ack = cyc;
      end
      if (rstn && valid) begin
         if (first_valid < 0) first_valid = cyc;
         if (!stall && !redirect) begin
            pc_q.push_back(pc);
            inst_q.push_back(inst);
         end
      end
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      lat = 0;
      step(0, 0, '0);
      step(0, 0, '0);
      rstn = 1'b1;
      acc_q.delete();
      pc_q.delete();
      inst_q.delete();
      first_ack = -1;
      first_valid = -1;
      fired = 1'b0;
      wait_cnt = 0;
      cyc = 0;
   endtask

   initial begin
      ibus.ack  = 1'b0;
      ibus.data = '0;

      // reset state
      do_reset();
      check("rst_req", 64'(ibus.req), 64'd0);
      check("rst_valid", 64'(valid), 64'd0);
      check("rst_exc", 64'(exc), 64'd0);
      check("rst_inst", 64'(inst), 64'h13);
      check("rst_pc", 64'(pc), 64'd0);

      // 1: zero-wait bus, no stall
      step(0, 0, '0);
      check("t1_req", 64'(ibus.req), 64'd1);
      check("t1_addr0", 64'(ibus.addr), 64'd0);
      for (int i = 0; i < 9; i++) step(0, 0, '0);
      check("t1_nacc", 64'(acc_q.size()), 64'd10);
      check("t1_ncons", 64'(pc_q.size()), 64'd9);
      for (int i = 0; i < 9; i++) begin
         if (i < acc_q.size()) check("t1_acc", 64'(acc_q[i]), 64'(4 * i));
         if (i < pc_q.size()) begin
            check("t1_pc", 64'(pc_q[i]), 64'(4 * i));
            check("t1_inst", 64'(inst_q[i]), 64'(32'h1000_0000 + 4 * i));
         end
      end
      check("t1_latency", 64'(first_valid - first_ack), 64'd1);

      // 2: stall fills the buffer, release drains in order
      do_reset();
      for (int i = 0; i < 6; i++) step(1, 0, '0);
      check("t2_nacc", 64'(acc_q.size()), 64'd2);
      check("t2_req_drop", 64'(ibus.req), 64'd0);
      check("t2_valid", 64'(valid), 64'd1);
      check("t2_head_pc", 64'(pc), 64'd0);
      check("t2_head_inst", 64'(inst), 64'h1000_0000);
      for (int i = 0; i < 6; i++) step(0, 0, '0);
      check("t2_ncons", 64'(pc_q.size()), 64'd6);
      for (int i = 0; i < 6; i++)
         if (i < pc_q.size()) check("t2_pc", 64'(pc_q[i]), 64'(4 * i));

      // 3: redirect while a slow request is pending
      do_reset();
      lat = 3;
      step(0, 0, '0);
      step(0, 1, 32'h100);
      for (int i = 0; i < 6; i++) begin
         step(0, 0, '0);
         check("t3_nostale", 64'(valid), 64'd0);
         if (i == 2) begin
            check("t3_req", 64'(ibus.req), 64'd1);
            check("t3_addr", 64'(ibus.addr), 64'h100);
         end
      end
      step(0, 0, '0);
      check("t3_nacc", 64'(acc_q.size()), 64'd2);
      if (acc_q.size() == 2) check("t3_acc1", 64'(acc_q[1]), 64'h100);
      check("t3_ncons", 64'(pc_q.size()), 64'd1);
      if (pc_q.size() == 1) begin
         check("t3_pc", 64'(pc_q[0]), 64'h100);
         check("t3_inst", 64'(inst_q[0]), 64'h1000_0100);
      end

      // 4: redirect together with ack and pop while buffer+pending is full
      do_reset();
      lat = 1;
      step(1, 0, '0);
      step(1, 0, '0);
      step(1, 0, '0);
      check("t4_valid_pre", 64'(valid), 64'd1);
      check("t4_addr_pre", 64'(ibus.addr), 64'd4);
      step(0, 1, 32'h100);
      check("t4_ack_seen", 64'(acc_q.size()), 64'd2);
      step(0, 0, '0);
      check("t4_req", 64'(ibus.req), 64'd1);
      check("t4_addr", 64'(ibus.addr), 64'h100);
      check("t4_flushed", 64'(valid), 64'd0);
      step(0, 0, '0);
      check("t4_flushed2", 64'(valid), 64'd0);
      step(0, 0, '0);
      check("t4_valid", 64'(valid), 64'd1);
      check("t4_pc", 64'(pc), 64'h100);
      check("t4_ncons", 64'(pc_q.size()), 64'd1);

      // 5: reset in the middle of a request
      do_reset();
      for (int i = 0; i < 3; i++) step(0, 0, '0);
      lat = 3;
      step(0, 0, '0);
      check("t5_addr_pre", 64'(ibus.addr), 64'd12);
      rstn = 1'b0;
      step(0, 0, '0);
      check("t5_req", 64'(ibus.req), 64'd0);
      check("t5_valid", 64'(valid), 64'd0);
      rstn = 1'b1;
      step(0, 0, '0);
      check("t5_restart_req", 64'(ibus.req), 64'd1);
      check("t5_restart_addr", 64'(ibus.addr), 64'd0);
      check("t5_valid2", 64'(valid), 64'd0);

      // 6: misaligned redirect target
      do_reset();
      step(0, 0, '0);
      step(0, 1, 32'h102);
`ifdef IF_MISALIGN_EXC_EN
      step(0, 0, '0);
      check("t6_req_blk", 64'(ibus.req), 64'd0);
      step(0, 0, '0);
      check("t6_valid", 64'(valid), 64'd1);
      check("t6_exc", 64'(exc), 64'd1);
      check("t6_pc", 64'(pc), 64'h102);
      check("t6_inst", 64'(inst), 64'h13);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, '0);
         check("t6_no_req", 64'(ibus.req), 64'd0);
      end
      check("t6_drained", 64'(valid), 64'd0);
      step(0, 1, 32'h200);
      step(0, 0, '0);
      check("t6_req_new", 64'(ibus.req), 64'd1);
      check("t6_addr_new", 64'(ibus.addr), 64'h200);
`else
      step(0, 0, '0);
      check("t6_req", 64'(ibus.req), 64'd1);
      check("t6_addr", 64'(ibus.addr), 64'h100);
      step(0, 0, '0);
      check("t6_valid", 64'(valid), 64'd1);
      check("t6_pc", 64'(pc), 64'h100);
      check("t6_exc", 64'(exc), 64'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
